// File: rtl/figure_3_pkg.sv
// Shared types and command encodings for the figure_3 clear/load/shift controller.
package figure_3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] CMD_END     = 2'd0;
  localparam logic [1:0] CMD_SHIFT   = 2'd1;
  localparam logic [1:0] CMD_LOAD    = 2'd2;
  localparam logic [1:0] CMD_END_ALT = 2'd3;

endpackage

// File: rtl/figure_3.sv
// Controller sequencing datapath clear/load/shift from a start request and command A.
// Optional: define FIGURE_3_ABORT_EN to let start=0 abort a run in CLR or RUN.
module figure_3
  import figure_3_pkg::*;
(
  input  logic       clock,
  input  logic       n_reset,
  input  logic       start,
  input  logic [1:0] A,
  output logic       clear,
  output logic       load,
  output logic       shift,
  output logic       ready
);

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clock) begin
    if (!n_reset) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = IDLE;
    clear  = 1'b0;
    load   = 1'b0;
    shift  = 1'b0;
    ready  = 1'b0;
    case (r_state)
      IDLE: begin
        ready  = 1'b1;
        w_next = start ? CLR : IDLE;
      end
      CLR: begin
        clear  = 1'b1;
        w_next = RUN;
`ifdef FIGURE_3_ABORT_EN
        if (!start) w_next = IDLE;
`endif
      end
      RUN: begin
        case (A)
          CMD_SHIFT: begin
            shift  = 1'b1;
            w_next = RUN;
          end
          CMD_LOAD: begin
            load   = 1'b1;
            w_next = RUN;
          end
          default: w_next = DONE;
        endcase
`ifdef FIGURE_3_ABORT_EN
        // Abort only redirects the next state; this cycle's outputs still follow A.
        if (!start) w_next = IDLE;
`endif
      end
      DONE: begin
        ready  = 1'b1;
        w_next = start ? DONE : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_figure_3.sv
// Scoreboard bench for figure_3: rows of {n_reset,start,A,expected {ready,clear,load,shift}}.
module tb_figure_3;

  logic       clock;
  logic       n_reset;
  logic       start;
  logic [1:0] A;
  logic       clear;
  logic       load;
  logic       shift;
  logic       ready;

  logic [3:0] sb[$];
  int unsigned n_checks;
  int unsigned n_pass;

  localparam logic [3:0] R = 4'b1000;
  localparam logic [3:0] C = 4'b0100;
  localparam logic [3:0] L = 4'b0010;
  localparam logic [3:0] S = 4'b0001;
  localparam logic [3:0] N = 4'b0000;

  figure_3 dut (
    .clock   (clock),
    .n_reset (n_reset),
    .start   (start),
    .A       (A),
    .clear   (clear),
    .load    (load),
    .shift   (shift),
    .ready   (ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] row(input logic nr, input logic st,
                                     input logic [1:0] a, input logic [3:0] e);
    return {nr, st, a, e};
  endfunction

  // Drive one cycle's inputs just after the edge, record the expectation, sample at negedge.
  task automatic drive(input logic [7:0] r);
    @(posedge clock);
    #1;
    n_reset = r[7];
    start   = r[6];
    A       = r[5:4];
    sb.push_back(r[3:0]);
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [7:0] rows[$];
    logic [3:0] got, exp;
    rows = '{row(0,1,0,R), row(0,1,0,R), row(1,1,0,R), row(1,1,0,C),
             row(1,1,0,N), row(1,1,0,R), row(1,0,0,R), row(1,0,0,R)};
    foreach (rows[i]) begin
      drive(rows[i]);
      got = {ready, clear, load, shift};
      exp = sb.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL reset row %0d: got %b expected %b", i, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_basic_run();
    logic [7:0] rows[$];
    logic [3:0] got, exp;
    rows = '{row(1,0,0,R), row(1,1,0,R), row(1,1,0,C), row(1,1,0,N),
             row(1,1,0,R), row(1,1,0,R), row(1,0,0,R), row(1,0,0,R)};
    foreach (rows[i]) begin
      drive(rows[i]);
      got = {ready, clear, load, shift};
      exp = sb.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL basic_run row %0d: got %b expected %b", i, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_commands();
    logic [7:0] rows[$];
    logic [3:0] got, exp;
    rows = '{row(1,1,0,R), row(1,1,0,C), row(1,1,1,S), row(1,1,2,L),
             row(1,1,1,S), row(1,1,0,N), row(1,0,0,R), row(1,1,0,R),
             row(1,1,2,C), row(1,1,3,N), row(1,1,3,R), row(1,0,0,R),
             row(1,0,0,R)};
    foreach (rows[i]) begin
      drive(rows[i]);
      got = {ready, clear, load, shift};
      exp = sb.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL commands row %0d: got %b expected %b", i, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    logic [7:0] rows[$];
    logic [3:0] got, exp;
`ifdef FIGURE_3_ABORT_EN
    rows = '{row(1,1,0,R), row(1,1,0,C), row(1,0,1,S), row(1,0,0,R),
             row(1,1,0,R), row(1,0,2,C), row(1,0,0,R)};
`else
    rows = '{row(1,1,0,R), row(1,1,0,C), row(1,0,1,S), row(1,0,1,S),
             row(1,0,0,N), row(1,0,0,R), row(1,1,0,R), row(1,0,2,C),
             row(1,0,0,N), row(1,0,0,R), row(1,0,0,R)};
`endif
    foreach (rows[i]) begin
      drive(rows[i]);
      got = {ready, clear, load, shift};
      exp = sb.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL abort row %0d: got %b expected %b", i, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_mid_run_reset();
    logic [7:0] rows[$];
    logic [3:0] got, exp;
    rows = '{row(1,1,0,R), row(1,1,0,C), row(1,1,2,L), row(0,1,2,L),
             row(1,0,2,R), row(1,1,0,R), row(0,1,0,C), row(1,1,0,R),
             row(1,1,0,C), row(1,1,0,N), row(0,1,0,R), row(1,0,0,R)};
    foreach (rows[i]) begin
      drive(rows[i]);
      got = {ready, clear, load, shift};
      exp = sb.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL mid_run_reset row %0d: got %b expected %b", i, got, exp);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_reset  = 1'b0;
    start    = 1'b1;
    A        = 2'd0;
    test_reset();
    test_basic_run();
    test_commands();
    test_abort();
    test_mid_run_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
